// File: rtl/mipi_csi_pkg.sv
// Shared definitions for the CSI-2 long-packet CRC checker: CRC constants,
// default long-packet data-type threshold and the checker state encoding.
package mipi_csi_pkg;

  // CRC-16 (x^16+x^12+x^5+1), processed LSB-first, no final XOR
  localparam logic [15:0] CrcInit = 16'hFFFF;
  localparam logic [15:0] CrcPoly = 16'h8408;

  // Data types at or above this value carry a payload and a checksum
  localparam logic [5:0] LongDtMinDefault = 6'h10;

  typedef enum logic [2:0] {
    StIdle,
    StPayload,
    StCrcWait,
    StCrcSplit,
    StCheck,
    StDrain
  } crc_state_e;

endpackage

// File: rtl/mipi_csi_crc_checker_if.sv
// Stream tap and status bundle for mipi_csi_crc_checker.
// Statistics signals exist only when MIPI_CRC_STATS_EN is defined.
interface mipi_csi_crc_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic        data_valid_i;
  logic [31:0] data_i;
  logic        crc_done_o;
  logic        crc_ok_o;
  logic [15:0] crc_calc_o;
  logic [15:0] crc_rx_o;
  logic [5:0]  data_type_o;
  logic [15:0] word_count_o;
  logic        truncated_o;
`ifdef MIPI_CRC_STATS_EN
  logic             stats_clear_i;
  logic [CNT_W-1:0] pkt_count_o;
  logic [CNT_W-1:0] err_count_o;

  // Source side: drives the lane-aligned stream, observes status
  modport master (
    output data_valid_i, data_i, stats_clear_i,
    input  crc_done_o, crc_ok_o, crc_calc_o, crc_rx_o, data_type_o, word_count_o,
    input  truncated_o, pkt_count_o, err_count_o
  );

  // Checker side
  modport slave (
    input  data_valid_i, data_i, stats_clear_i,
    output crc_done_o, crc_ok_o, crc_calc_o, crc_rx_o, data_type_o, word_count_o,
    output truncated_o, pkt_count_o, err_count_o
  );
`else
  // Source side: drives the lane-aligned stream, observes status
  modport master (
    output data_valid_i, data_i,
    input  crc_done_o, crc_ok_o, crc_calc_o, crc_rx_o, data_type_o, word_count_o,
    input  truncated_o
  );

  // Checker side
  modport slave (
    input  data_valid_i, data_i,
    output crc_done_o, crc_ok_o, crc_calc_o, crc_rx_o, data_type_o, word_count_o,
    output truncated_o
  );
`endif
endinterface

// File: rtl/mipi_csi_crc16_step.sv
// Combinational CSI-2 CRC-16 update over up to four bytes of a 32-bit word.
// Enabled bytes are folded in order byte 0 -> byte 3; disabled bytes are skipped.
module mipi_csi_crc16_step
  import mipi_csi_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  be_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_acc;

  // Bit-serial reflected CRC unrolled across the enabled bytes
  always_comb begin
    crc_acc = crc_i;
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) begin
        crc_acc = crc_acc ^ {8'h00, data_i[8*b +: 8]};
        for (int k = 0; k < 8; k++) begin
          crc_acc = crc_acc[0] ? ((crc_acc >> 1) ^ CrcPoly) : (crc_acc >> 1);
        end
      end
    end
    crc_o = crc_acc;
  end

endmodule

// File: rtl/mipi_csi_crc_checker.sv
// CSI-2 long-packet payload CRC checker. Taps the 4-byte lane-aligned stream,
// parses the header, runs CRC-16 over WC payload bytes and compares it with the
// received little-endian checksum. The stream itself is not modified.
// Optional statistics counters are built when MIPI_CRC_STATS_EN is defined.
module mipi_csi_crc_checker
  import mipi_csi_pkg::*;
#(
  parameter logic [5:0]  LONG_DT_MIN = LongDtMinDefault,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  mipi_csi_crc_checker_if.slave csi_io
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  logic        valid;
  logic [31:0] data;

  assign valid = csi_io.data_valid_i;
  assign data  = csi_io.data_i;

  crc_state_e  state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  rx_lo_q, rx_lo_d;
  logic [5:0]  hdr_dt_q, hdr_dt_d;
  logic [15:0] hdr_wc_q, hdr_wc_d;

  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic [15:0] calc_q, calc_d;
  logic [15:0] rx_q, rx_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] wc_q, wc_d;
  logic        trunc_q, trunc_d;

  logic [3:0]  step_be;
  logic [15:0] step_crc;

  logic        fin;
  logic [15:0] fin_calc;
  logic [15:0] fin_rx;

  // Byte enable for the payload word: all four unless fewer bytes remain
  always_comb begin
    step_be = 4'h0;
    if (rem_q >= 16'd4) begin
      step_be = 4'hF;
    end else begin
      case (rem_q[1:0])
        2'd1:    step_be = 4'h1;
        2'd2:    step_be = 4'h3;
        2'd3:    step_be = 4'h7;
        default: step_be = 4'h0;
      endcase
    end
  end

  mipi_csi_crc16_step u_crc_step (
    .crc_i  (crc_q),
    .data_i (data),
    .be_i   (step_be),
    .crc_o  (step_crc)
  );

  // Packet parsing FSM and result capture
  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    rem_d    = rem_q;
    rx_lo_d  = rx_lo_q;
    hdr_dt_d = hdr_dt_q;
    hdr_wc_d = hdr_wc_q;
    done_d   = 1'b0;
    ok_d     = ok_q;
    calc_d   = calc_q;
    rx_d     = rx_q;
    dt_d     = dt_q;
    wc_d     = wc_q;
    trunc_d  = 1'b0;
    fin      = 1'b0;
    fin_calc = crc_q;
    fin_rx   = rx_q;

    unique case (state_q)
      StIdle: begin
        if (valid) begin
          if (data[5:0] < LONG_DT_MIN) begin
            state_d = StDrain;
          end else begin
            crc_d    = CrcInit;
            rem_d    = data[23:8];
            hdr_dt_d = data[5:0];
            hdr_wc_d = data[23:8];
            state_d  = (data[23:8] == 16'd0) ? StCrcWait : StPayload;
          end
        end
      end

      StPayload: begin
        if (!valid) begin
          trunc_d = 1'b1;
          state_d = StIdle;
        end else begin
          crc_d = step_crc;
          if (rem_q > 16'd4) begin
            // Stays above zero, so WC = 16'hFFFF cannot wrap
            rem_d = rem_q - 16'd4;
          end else begin
            rem_d = 16'd0;
            case (rem_q[2:0])
              3'd1: begin
                fin      = 1'b1;
                fin_calc = step_crc;
                fin_rx   = data[23:8];
              end
              3'd2: begin
                fin      = 1'b1;
                fin_calc = step_crc;
                fin_rx   = data[31:16];
              end
              3'd3: begin
                rx_lo_d = data[31:24];
                state_d = StCrcSplit;
              end
              default: state_d = StCrcWait;
            endcase
          end
        end
      end

      StCrcWait: begin
        if (!valid) begin
          trunc_d = 1'b1;
          state_d = StIdle;
        end else begin
          fin      = 1'b1;
          fin_calc = crc_q;
          fin_rx   = data[15:0];
        end
      end

      StCrcSplit: begin
        if (!valid) begin
          trunc_d = 1'b1;
          state_d = StIdle;
        end else begin
          fin      = 1'b1;
          fin_calc = crc_q;
          fin_rx   = {data[7:0], rx_lo_q};
        end
      end

      // Valid may already be low on the cycle after the CRC word
      StCheck: state_d = valid ? StDrain : StIdle;

      StDrain: begin
        if (!valid) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (fin) begin
      state_d = StCheck;
      done_d  = 1'b1;
      ok_d    = (fin_calc == fin_rx);
      calc_d  = fin_calc;
      rx_d    = fin_rx;
      dt_d    = hdr_dt_q;
      wc_d    = hdr_wc_q;
    end
  end

  // State and result registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= StIdle;
      crc_q    <= CrcInit;
      rem_q    <= 16'd0;
      rx_lo_q  <= 8'd0;
      hdr_dt_q <= 6'd0;
      hdr_wc_q <= 16'd0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      calc_q   <= CrcInit;
      rx_q     <= 16'd0;
      dt_q     <= 6'd0;
      wc_q     <= 16'd0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      rem_q    <= rem_d;
      rx_lo_q  <= rx_lo_d;
      hdr_dt_q <= hdr_dt_d;
      hdr_wc_q <= hdr_wc_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      calc_q   <= calc_d;
      rx_q     <= rx_d;
      dt_q     <= dt_d;
      wc_q     <= wc_d;
      trunc_q  <= trunc_d;
    end
  end

  assign csi_io.crc_done_o   = done_q;
  assign csi_io.crc_ok_o     = ok_q;
  assign csi_io.crc_calc_o   = calc_q;
  assign csi_io.crc_rx_o     = rx_q;
  assign csi_io.data_type_o  = dt_q;
  assign csi_io.word_count_o = wc_q;
  assign csi_io.truncated_o  = trunc_q;

`ifdef MIPI_CRC_STATS_EN
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             pkt_inc;
  logic             err_inc;

  // Saturating counters; a clear in the same cycle as an increment wins
  always_comb begin
    pkt_inc   = done_q;
    err_inc   = (done_q & ~ok_q) | trunc_q;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (csi_io.stats_clear_i) begin
      pkt_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (pkt_inc && (pkt_cnt_q != '1)) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
      if (err_inc && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign csi_io.pkt_count_o = pkt_cnt_q;
  assign csi_io.err_count_o = err_cnt_q;
`endif

endmodule

// File: doc/mipi_csi_crc_checker.md
# mipi_csi_crc_checker

Long-packet payload CRC checker for the CSI-2 receive path. Sits directly downstream of `mipi_rx_lane_aligner`, in parallel with `mipi_csi_packet_decoder`, and taps the same 4-byte lane-aligned stream. It parses each packet header, computes the CSI-2 CRC-16 over exactly WC payload bytes, and compares it with the received checksum. Status is reported per packet; the data stream itself is not modified.

## Interface
Parameters:
- LONG_DT_MIN, 6'h10: lowest data type treated as a long packet.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk_i  in  1  byte clock. One clock; reset is asynchronous and active-low.
- reset_n_i  in  1  asynchronous active-low reset.
- data_valid_i  in  1  lane-aligned valid; high for the whole packet.
- data_i  in  32  lane-aligned bytes; [7:0] is the earliest byte.
- crc_done_o  out  1  one-cycle pulse when a long-packet check completes.
- crc_ok_o  out  1  qualified by crc_done_o; high when calculated CRC == received CRC.
- crc_calc_o  out  16  calculated CRC, held until the next crc_done_o.
- crc_rx_o  out  16  received CRC, held until the next crc_done_o.
- data_type_o  out  6  DI[5:0] of the last header, held.
- word_count_o  out  16  WC of the last header, held.
- truncated_o  out  1  one-cycle pulse when valid drops before the CRC is complete.
- stats_clear_i  in  1  synchronous clear of the counters (MIPI_CRC_STATS_EN only).
- pkt_count_o  out  CNT_W  completed long packets (MIPI_CRC_STATS_EN only).
- err_count_o  out  CNT_W  CRC mismatches plus truncations (MIPI_CRC_STATS_EN only).

## Operation
- Header word: the first valid cycle after idle. DI = [7:0], WC = [23:8] (little-endian), ECC = [31:24]. ECC is not checked.
- CRC definition:
  - Polynomial x^16+x^12+x^5+1, processed LSB-first (reflected constant 16'h8408).
  - Init 16'hFFFF. No final XOR.
  - Received CRC is little-endian: low byte first.
- The CRC step processes 1 to 4 bytes per cycle under a byte-enable mask.
- State machine:
  - IDLE:
    - On valid with DI[5:0] < LONG_DT_MIN: go to DRAIN (short packet, no check).
    - On a long packet: load crc = 16'hFFFF and rem = WC, then go to PAYLOAD. If WC == 0, go straight to CRC_WAIT.
  - PAYLOAD (consumes min(rem, 4) bytes per valid cycle; rem -= 4):
    - Final word, r = WC mod 4:
      - r = 1: CRC is bytes 1,2 → CHECK.
      - r = 2: CRC is bytes 2,3 → CHECK.
      - r = 3: byte 3 is CRC low byte → CRC_SPLIT.
      - r = 0: → CRC_WAIT.
  - CRC_WAIT: next valid word, bytes 0,1 are the CRC → CHECK.
  - CRC_SPLIT: next valid word, byte 0 is the CRC high byte → CHECK.
  - CHECK: register the results and pulse crc_done_o. Then go to DRAIN, or to IDLE if valid is already low.
  - DRAIN: wait for data_valid_i low, then IDLE.
- Valid falling in PAYLOAD, CRC_WAIT or CRC_SPLIT: pulse truncated_o, emit no crc_done_o, go to IDLE.
- rem is a 16-bit counter. The WC = 16'hFFFF maximum must not wrap.

## Timing
- Reset values:
  - All outputs 0, except crc_calc_o = 16'hFFFF.
  - State IDLE.
  - Reset asserted mid-packet aborts silently, with no pulse.
- Latency: crc_done_o asserts exactly 1 clk_i after the cycle carrying the last CRC byte.
- crc_ok_o, crc_calc_o, crc_rx_o, data_type_o and word_count_o update on that same edge.
- Back-to-back packets need at least one cycle with valid low between them. The CHECK → IDLE path handles valid dropping on the CRC word.
- Simultaneous stats_clear_i and increment: clear wins. Counters saturate at all-ones.

## Configuration
- Macro MIPI_CRC_STATS_EN.
- Defined: stats_clear_i, pkt_count_o and err_count_o exist. pkt_count_o increments on crc_done_o. err_count_o increments on (crc_done_o & !crc_ok_o) | truncated_o.
- Undefined: the three ports and the counter logic are absent. All other behaviour is identical.

## Structure
- Shared package `mipi_csi_pkg` holds:
  - CRC init 16'hFFFF and poly 16'h8408.
  - LONG_DT_MIN default.
  - The state enum typedef.
- One sub-module, `mipi_csi_crc16_step`: combinational. Inputs: crc_in[15:0], data[31:0], byte-enable[3:0]. Output: crc_out. Enabled bytes are processed in order 0→3.

## Test plan
- Spec vector A: DI 0x2B, WC 24. Payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01, CRC word F0 00 → crc_ok_o=1, crc_calc_o=16'h00F0.
- Spec vector B: payload FF 00 00 00 1E F0 1E C7 4F 82 78 C5 82 E0 8C 70 D2 3C 78 E9 FF 00 00 01, CRC bytes 69 E5 → crc_ok_o=1, crc_calc_o=16'hE569.
- WC = 1, 2, 3, 5 with correct CRCs → crc_ok_o=1 each time. WC=3 exercises CRC_SPLIT. Flipping one payload bit → crc_ok_o=0 and err_count_o increments.
- Short packet (DI 0x00, frame start) → no crc_done_o; state returns to IDLE after valid drops.
- Valid drops after 8 of 24 payload bytes → truncated_o pulses once, no crc_done_o. The next good packet checks OK.
- WC = 0, CRC word FF FF → crc_ok_o=1 one cycle after that word. reset_n_i low mid-payload → all outputs reset, no pulses.
